barrel_shift_l_pipe: RTL and testbench

Pipelined left barrel rotator with valid/ready handshakes on both sides. It is the left-direction counterpart of the combinational right rotator. It accepts one word per cycle and rotates it left by `amt`, using one registered stage per amount bit. It sits between a producer and consumer datapath that need registered, back-pressurable shifting in place of a long combinational mux chain.

---
 rtl/barrel_pkg.sv | 37 +++
 rtl/barrel_l_stage.sv | 70 +++++++
 rtl/barrel_shift_l_pipe.sv | 84 ++++++++
 tb/tb_barrel_shift_l_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared barrel shifter helpers: data width derivation and the per-stage
// rotate / zero-fill shift function used by both the left and right rotators.
package barrel_pkg;

    // Widest data path the stage function handles (ADDRESS_BITS up to 6).
    localparam int MAX_WIDTH    = 64;
    localparam int MAX_IDX_BITS = 6;

    // Data width is always a power of two set by the shift amount width.
    function automatic int barrel_width(input int address_bits);
        return 1 << address_bits;
    endfunction

    // Moves the low 'width' bits of d left by s positions. Vacated low bits
    // take the wrapped-around high bits, or zeros when zero_fill is set.
    // Bits at and above 'width' always come back as zero.
    function automatic logic [MAX_WIDTH-1:0] barrel_stage(
        input logic [MAX_WIDTH-1:0] d,
        input int                   width,
        input int                   s,
        input logic                 zero_fill
    );
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                if (i >= s) begin
                    r[MAX_IDX_BITS'(i)] = d[MAX_IDX_BITS'(i - s)];
                end else if (!zero_fill) begin
                    r[MAX_IDX_BITS'(i)] = d[MAX_IDX_BITS'(i - s + width)];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_l_stage.sv
// One stage of the pipelined left rotator: conditionally rotates the
// incoming word by 2**K (selected by amount bit K) and registers the word,
// its valid flag and its amount. Optional zero-fill flag follows the word
// when BARREL_SHIFT_L_LOGICAL_EN is defined.
module barrel_l_stage
    import barrel_pkg::*;
#(
    parameter int ADDRESS_BITS = 3,
    parameter int K            = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               adv,
    input  logic                               prev_valid,
    input  logic [barrel_width(ADDRESS_BITS)-1:0] prev_data,
    input  logic [ADDRESS_BITS-1:0]            prev_amt,
`ifdef BARREL_SHIFT_L_LOGICAL_EN
    input  logic                               prev_logical,
    output logic                               logical_q,
`endif
    output logic                               valid_q,
    output logic [barrel_width(ADDRESS_BITS)-1:0] data_q,
    output logic [ADDRESS_BITS-1:0]            amt_q
);

    localparam int WIDTH = barrel_width(ADDRESS_BITS);

    logic [MAX_WIDTH-1:0] wide_in;
    logic [MAX_WIDTH-1:0] wide_out;
    logic [WIDTH-1:0]     moved;
    logic                 zero_fill;

`ifdef BARREL_SHIFT_L_LOGICAL_EN
    assign zero_fill = prev_logical;
`else
    assign zero_fill = 1'b0;
`endif

    assign wide_in  = MAX_WIDTH'(prev_data);
    assign wide_out = barrel_stage(wide_in, WIDTH, 1 << K, zero_fill);
    assign moved    = wide_out[WIDTH-1:0];

    // The stage function works on the widest path; the bits above WIDTH are always zero here.
    generate
        if (WIDTH < MAX_WIDTH) begin : g_pad
            logic unused_high;
            assign unused_high = ^wide_out[MAX_WIDTH-1:WIDTH];
        end
    endgenerate

    // Load from the predecessor whenever the pipeline advances, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            amt_q     <= '0;
`ifdef BARREL_SHIFT_L_LOGICAL_EN
            logical_q <= 1'b0;
`endif
        end else if (adv) begin
            valid_q   <= prev_valid;
            data_q    <= prev_amt[K] ? moved : prev_data;
            amt_q     <= prev_amt;
`ifdef BARREL_SHIFT_L_LOGICAL_EN
            logical_q <= prev_logical;
`endif
        end
    end

endmodule

// File: rtl/barrel_shift_l_pipe.sv
// Pipelined left barrel rotator with valid/ready on both sides. One
// registered stage per amount bit; the whole pipeline advances together and
// freezes while the consumer back-pressures a valid result.
// Optional feature macro: BARREL_SHIFT_L_LOGICAL_EN adds a 'logical' input
// that turns the rotate into a zero-filling left shift for that word.
module barrel_shift_l_pipe
    import barrel_pkg::*;
#(
    parameter int ADDRESS_BITS = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ADDRESS_BITS-1:0]               amt,
    input  logic [barrel_width(ADDRESS_BITS)-1:0] num,
`ifdef BARREL_SHIFT_L_LOGICAL_EN
    input  logic                                  logical,
`endif
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [barrel_width(ADDRESS_BITS)-1:0] shifted,
    output logic [ADDRESS_BITS-1:0]               out_amt
);

    localparam int WIDTH = barrel_width(ADDRESS_BITS);

    // Index 0 is the input port, index k+1 is the output of stage k.
    logic                    valid_chain [0:ADDRESS_BITS];
    logic [WIDTH-1:0]        data_chain  [0:ADDRESS_BITS];
    logic [ADDRESS_BITS-1:0] amt_chain   [0:ADDRESS_BITS];
    logic                    adv;

    // Everything moves unless a finished result is waiting on the consumer.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign valid_chain[0] = in_valid;
    assign data_chain[0]  = num;
    assign amt_chain[0]   = amt;

    assign out_valid = valid_chain[ADDRESS_BITS];
    assign shifted   = data_chain[ADDRESS_BITS];
    assign out_amt   = amt_chain[ADDRESS_BITS];

`ifdef BARREL_SHIFT_L_LOGICAL_EN
    // The flag is only consumed inside stages, so the last stage's copy goes nowhere.
    logic logical_chain [0:ADDRESS_BITS-1];
    logic unused_logical;
    assign logical_chain[0] = logical;
`endif

    generate
        for (genvar k = 0; k < ADDRESS_BITS; k++) begin : g_stage
`ifdef BARREL_SHIFT_L_LOGICAL_EN
            logic flag_out;
            if (k < ADDRESS_BITS - 1) begin : g_pass
                assign logical_chain[k+1] = flag_out;
            end else begin : g_last
                assign unused_logical = flag_out;
            end
`endif
            barrel_l_stage #(
                .ADDRESS_BITS (ADDRESS_BITS),
                .K            (k)
            ) u_stage (
                .clk          (clk),
                .reset        (reset),
                .adv          (adv),
                .prev_valid   (valid_chain[k]),
                .prev_data    (data_chain[k]),
                .prev_amt     (amt_chain[k]),
`ifdef BARREL_SHIFT_L_LOGICAL_EN
                .prev_logical (logical_chain[k]),
                .logical_q    (flag_out),
`endif
                .valid_q      (valid_chain[k+1]),
                .data_q       (data_chain[k+1]),
                .amt_q        (amt_chain[k+1])
            );
        end
    endgenerate

endmodule

// File: tb/tb_barrel_shift_l_pipe.sv
// Directed and scoreboard bench for the pipelined left rotator (ADDRESS_BITS = 3).
module tb_barrel_shift_l_pipe;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] amt;
    logic [7:0] num;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] shifted;
    logic [2:0] out_amt;
`ifdef BARREL_SHIFT_L_LOGICAL_EN
    logic       logical;
`endif

    int compared;
    int mismatched;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] amt;
    } sb_t;

    sb_t sb_q [$];

    // Stall scenario tables, indexed by cycle 0..12.
    logic       st_in_valid [13] = '{1,1,1,1,1,1,1,1,1,0,0,0,0};
    logic [7:0] st_num      [13] = '{8'h81,8'h01,8'h5A,8'hB4,8'h0F,8'h0F,8'h0F,8'h0F,8'h0F,8'h00,8'h00,8'h00,8'h00};
    logic [2:0] st_amt      [13] = '{3'd1,3'd7,3'd0,3'd3,3'd4,3'd4,3'd4,3'd4,3'd4,3'd0,3'd0,3'd0,3'd0};
    logic       st_out_rdy  [13] = '{1,1,1,1,0,0,0,0,1,1,1,1,1};
    logic       st_exp_in_r [13] = '{1,1,1,1,0,0,0,0,1,1,1,1,1};
    logic       st_exp_v    [13] = '{0,0,0,1,1,1,1,1,1,1,1,1,0};
    logic [7:0] st_exp_d    [13] = '{8'h00,8'h00,8'h00,8'h03,8'h80,8'h80,8'h80,8'h80,8'h80,8'h5A,8'hA5,8'hF0,8'h00};
    logic [2:0] st_exp_a    [13] = '{3'd0,3'd0,3'd0,3'd1,3'd7,3'd7,3'd7,3'd7,3'd7,3'd0,3'd3,3'd4,3'd0};

    barrel_shift_l_pipe #(
        .ADDRESS_BITS (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .amt       (amt),
        .num       (num),
`ifdef BARREL_SHIFT_L_LOGICAL_EN
        .logical   (logical),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .shifted   (shifted),
        .out_amt   (out_amt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] rotl8(input logic [7:0] n, input logic [2:0] a);
        logic [15:0] t;
        t = {n, n} << a;
        return t[15:8];
    endfunction

    // Move to the middle of the next cycle and present this cycle's inputs.
    task automatic applyStimulus(input logic v, input logic [7:0] n, input logic [2:0] a,
                                 input logic ordy);
        @(negedge clk);
        in_valid  = v;
        num       = n;
        amt       = a;
        out_ready = ordy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int   idx;
        int   cycles;
        sb_t  exp;
        logic v;
        logic r;

        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        num        = 8'h00;
        amt        = 3'd0;
        out_ready  = 1'b1;
`ifdef BARREL_SHIFT_L_LOGICAL_EN
        logical    = 1'b0;
`endif

        // Reset and idle
        applyStimulus(1'b1, 8'hFF, 3'd1, 1'b1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_shifted", 32'(shifted), 32'h00);
        checkOutput("idle_out_amt", 32'(out_amt), 32'd0);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("idle_no_garbage", 32'(out_valid), 32'd0);

        // Single word, latency of three cycles
        applyStimulus(1'b1, 8'hB4, 3'd3, 1'b1);
        checkOutput("single_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("single_c1_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("single_c2_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("single_c3_valid", 32'(out_valid), 32'd1);
        checkOutput("single_c3_shifted", 32'(shifted), 32'hA5);
        checkOutput("single_c3_amt", 32'(out_amt), 32'd3);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("single_c4_valid", 32'(out_valid), 32'd0);

        // Back-to-back stream
        applyStimulus(1'b1, 8'h81, 3'd1, 1'b1);
        applyStimulus(1'b1, 8'h01, 3'd7, 1'b1);
        applyStimulus(1'b1, 8'h5A, 3'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("b2b_c3_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_c3_shifted", 32'(shifted), 32'h03);
        checkOutput("b2b_c3_amt", 32'(out_amt), 32'd1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("b2b_c4_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_c4_shifted", 32'(shifted), 32'h80);
        checkOutput("b2b_c4_amt", 32'(out_amt), 32'd7);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("b2b_c5_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_c5_shifted", 32'(shifted), 32'h5A);
        checkOutput("b2b_c5_amt", 32'(out_amt), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("b2b_c6_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);

        // Stream with consumer stall in cycles 4..7
        for (int c = 0; c < 13; c++) begin
            applyStimulus(st_in_valid[c], st_num[c], st_amt[c], st_out_rdy[c]);
            checkOutput($sformatf("stall_c%0d_in_ready", c), 32'(in_ready), 32'(st_exp_in_r[c]));
            checkOutput($sformatf("stall_c%0d_valid", c), 32'(out_valid), 32'(st_exp_v[c]));
            if (st_exp_v[c]) begin
                checkOutput($sformatf("stall_c%0d_shifted", c), 32'(shifted), 32'(st_exp_d[c]));
                checkOutput($sformatf("stall_c%0d_amt", c), 32'(out_amt), 32'(st_exp_a[c]));
            end
        end

        // Reset while words are in flight
        applyStimulus(1'b1, 8'h11, 3'd2, 1'b1);
        applyStimulus(1'b1, 8'h22, 3'd3, 1'b1);
        applyStimulus(1'b1, 8'h33, 3'd4, 1'b1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("flight_valid", 32'(out_valid), 32'd1);
        checkOutput("flight_shifted", 32'(shifted), 32'h44);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_shifted", 32'(shifted), 32'h00);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        reset = 1'b0;
        applyStimulus(1'b1, 8'h96, 3'd5, 1'b1);
        checkOutput("post_rst_c0_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("post_rst_c1_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("post_rst_c2_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("post_rst_c3_valid", 32'(out_valid), 32'd1);
        checkOutput("post_rst_c3_shifted", 32'(shifted), 32'hD2);
        checkOutput("post_rst_c3_amt", 32'(out_amt), 32'd5);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("post_rst_c4_valid", 32'(out_valid), 32'd0);

`ifdef BARREL_SHIFT_L_LOGICAL_EN
        // Zero-fill versus rotate for the same word
        logical = 1'b1;
        applyStimulus(1'b1, 8'hB4, 3'd3, 1'b1);
        logical = 1'b0;
        applyStimulus(1'b1, 8'hB4, 3'd3, 1'b1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("logical_valid", 32'(out_valid), 32'd1);
        checkOutput("logical_shifted", 32'(shifted), 32'hA0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkOutput("rotate_valid", 32'(out_valid), 32'd1);
        checkOutput("rotate_shifted", 32'(shifted), 32'hA5);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
`endif

        // Every num x amt with random producer/consumer pacing
        idx    = 0;
        cycles = 0;
        while ((idx < 2048 || sb_q.size() != 0) && cycles < 20000) begin
            v = (idx < 2048) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            applyStimulus(v, 8'(idx), 3'(idx >> 8), r);
            if (out_valid && out_ready) begin
                checkOutput("sb_spurious", 32'(sb_q.size() == 0), 32'd0);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    checkOutput("sb_shifted", 32'(shifted), 32'(exp.data));
                    checkOutput("sb_amt", 32'(out_amt), 32'(exp.amt));
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back('{data: rotl8(num, amt), amt: amt});
                idx++;
            end
            cycles++;
        end
        checkOutput("sb_complete", 32'(idx == 2048 && sb_q.size() == 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
